audio_sample_tx: RTL



---
 rtl/audio_tx_pkg.sv | 18 +
 rtl/audio_sample_fifo.sv | 48 ++++
 rtl/audio_sample_tx.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/audio_tx_pkg.sv
// Shared types and constants for the I2S audio sample transmitter.
package audio_tx_pkg;

    typedef logic signed [15:0] sample_t;

    localparam int unsigned FRAME_BITS = 32;

    typedef enum logic [0:0] {IDLE, RUN} state_e;

    localparam logic LR_LEFT  = 1'b0;
    localparam logic LR_RIGHT = 1'b1;

    // Word select leads the data by one bit: right channel spans bits data_w-1 .. 2*data_w-2.
    function automatic logic lr_for_bit(input int unsigned bit_idx, input int unsigned data_w);
        return ((bit_idx >= data_w - 1) && (bit_idx <= 2 * data_w - 2)) ? LR_RIGHT : LR_LEFT;
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous sample FIFO with occupancy output; DEPTH must be a power of two >= 2.
module audio_sample_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = DEPTH[AW:0];

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              w_push;
    logic              w_pop;

    // Pointers carry one extra bit so full and empty stay distinct after wrap.
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_full  = (o_level == LVL_FULL);
    assign o_empty = (o_level == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (!i_rst_) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/audio_sample_tx.sv
// I2S transmitter: buffers mono samples and sends each on both channels, MSB first.
// Define AUDIO_TX_HOLD_LAST_EN to repeat the last sample on underrun instead of sending zero.
module audio_sample_tx
    import audio_tx_pkg::*;
#(
    parameter int unsigned DATA_W     = FRAME_BITS / 2,
    parameter int unsigned SCLK_DIV   = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst_,
    input  logic                           i_tx_en,
    input  logic signed [DATA_W-1:0]       i_s_data,
    input  logic                           i_s_valid,
    output logic                           o_s_ready,
    output logic                           o_sclk,
    output logic                           o_lrclk,
    output logic                           o_sdata,
    output logic                           o_underrun,
    output logic [$clog2(FIFO_DEPTH):0]    o_fifo_level
);

    localparam int unsigned WORD_W = 2 * DATA_W;
    localparam int unsigned BW     = $clog2(WORD_W);
    localparam int unsigned DW     = $clog2(SCLK_DIV);
    localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);

    state_e            r_state, w_state_next;
    logic [DW-1:0]     r_div_cnt, w_div_next;
    logic [BW-1:0]     r_bit_cnt, w_bit_cnt_next;
    logic              r_sclk, w_sclk_next;
    logic              r_lrclk, w_lrclk_next;
    logic              r_sdata, w_sdata_next;
    logic              r_underrun, w_underrun_next;
    logic [WORD_W-1:0] r_word, w_word_next;
    logic [DATA_W-1:0] r_next_word, w_next_word_next;

    logic              w_tick;
    logic              w_fall;
    logic [BW-1:0]     w_bit_next;
    logic              w_stop;
    logic              w_pop_slot;
    logic [DATA_W-1:0] w_fifo_data;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [DATA_W-1:0] w_fill;

    audio_sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_  (i_rst_),
        .i_push  (i_s_valid),
        .i_data  (i_s_data),
        .i_pop   (w_pop_slot),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (o_fifo_level)
    );

    assign w_tick     = (r_state == RUN) && (r_div_cnt == DIV_LAST);
    assign w_fall     = w_tick && r_sclk;
    assign w_bit_next = r_bit_cnt + 1'b1;
    assign w_stop     = w_fall && (w_bit_next == '0) && !i_tx_en;
    assign w_pop_slot = w_fall && (w_bit_next == BIT_LAST);

`ifdef AUDIO_TX_HOLD_LAST_EN
    logic [DATA_W-1:0] r_last;

    always_ff @(posedge i_clk) begin
        if (!i_rst_) begin
            r_last <= '0;
        end else if (w_pop_slot && !w_fifo_empty) begin
            r_last <= w_fifo_data;
        end
    end

    assign w_fill = r_last;
`else
    assign w_fill = '0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: if (i_tx_en) w_state_next = RUN;
            RUN:  if (w_stop)  w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_div_next       = r_div_cnt;
        w_bit_cnt_next   = r_bit_cnt;
        w_sclk_next      = r_sclk;
        w_lrclk_next     = r_lrclk;
        w_sdata_next     = r_sdata;
        w_underrun_next  = 1'b0;
        w_word_next      = r_word;
        w_next_word_next = r_next_word;
        unique case (r_state)
            IDLE: begin
                w_div_next     = '0;
                w_bit_cnt_next = BIT_LAST;
                w_sclk_next    = 1'b0;
                w_lrclk_next   = LR_RIGHT;
                w_sdata_next   = 1'b0;
            end
            RUN: begin
                if (w_stop) begin
                    // next_word is deliberately kept so the restart sends it.
                    w_div_next     = '0;
                    w_bit_cnt_next = BIT_LAST;
                    w_sclk_next    = 1'b0;
                    w_lrclk_next   = LR_RIGHT;
                    w_sdata_next   = 1'b0;
                end else if (w_tick) begin
                    w_div_next  = '0;
                    w_sclk_next = !r_sclk;
                    if (r_sclk) begin
                        w_bit_cnt_next = w_bit_next;
                        w_lrclk_next   = lr_for_bit(32'(w_bit_next), DATA_W);
                        if (w_bit_next == '0) begin
                            w_word_next  = {r_next_word, r_next_word};
                            w_sdata_next = r_next_word[DATA_W-1];
                        end else begin
                            w_sdata_next = r_word[BIT_LAST - w_bit_next];
                        end
                        if (w_pop_slot) begin
                            if (!w_fifo_empty) begin
                                w_next_word_next = w_fifo_data;
                            end else begin
                                w_next_word_next = w_fill;
                                w_underrun_next  = 1'b1;
                            end
                        end
                    end
                end else begin
                    w_div_next = r_div_cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_) begin
            r_div_cnt   <= '0;
            r_bit_cnt   <= BIT_LAST;
            r_sclk      <= 1'b0;
            r_lrclk     <= LR_RIGHT;
            r_sdata     <= 1'b0;
            r_underrun  <= 1'b0;
            r_word      <= '0;
            r_next_word <= '0;
        end else begin
            r_div_cnt   <= w_div_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_sclk      <= w_sclk_next;
            r_lrclk     <= w_lrclk_next;
            r_sdata     <= w_sdata_next;
            r_underrun  <= w_underrun_next;
            r_word      <= w_word_next;
            r_next_word <= w_next_word_next;
        end
    end

    assign o_s_ready  = !w_fifo_full;
    assign o_sclk     = r_sclk;
    assign o_lrclk    = r_lrclk;
    assign o_sdata    = r_sdata;
    assign o_underrun = r_underrun;

endmodule
